// File: rtl/pipeline_pkg.sv
// Shared pipeline constants: register-address widths, forwarding selects,
// the load result-source encoding and the PC-select redirect bit.
package pipeline_pkg;

   localparam int unsigned REG_ADDR_W   = 5;
   localparam int unsigned FWD_SEL_W    = 2;
   localparam int unsigned RESULT_SRC_W = 3;
   localparam int unsigned PC_SRC_W     = 2;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;
   typedef logic [FWD_SEL_W-1:0]  fwd_sel_t;

   localparam fwd_sel_t NO_FORWARD  = 2'b00;
   localparam fwd_sel_t WB_FORWARD  = 2'b01;
   localparam fwd_sel_t MEM_FORWARD = 2'b10;

   localparam logic [RESULT_SRC_W-1:0] RESULT_SRC_LOAD = 3'b100;

   localparam int unsigned PC_SRC_REDIRECT_BIT = 1;

endpackage

// File: rtl/hazard_ctrl_unit_forward_sel.sv
// Single-operand Execute-stage forwarding comparator; Memory result has
// priority over Writeback, and x0 is never forwarded.
module forward_sel
   import pipeline_pkg::*;
(
   input  logic [REG_ADDR_W-1:0] rs_e_i,
   input  logic [REG_ADDR_W-1:0] rd_m_i,
   input  logic                  reg_write_m_i,
   input  logic [REG_ADDR_W-1:0] rd_w_i,
   input  logic                  reg_write_w_i,
   output logic [FWD_SEL_W-1:0]  forward_o
);

   always_comb begin
      forward_o = NO_FORWARD;
      if (rs_e_i != '0) begin
         if (reg_write_m_i && (rs_e_i == rd_m_i)) begin
            forward_o = MEM_FORWARD;
         end else if (reg_write_w_i && (rs_e_i == rd_w_i)) begin
            forward_o = WB_FORWARD;
         end
      end
   end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: combinational stall/flush/forward controls.
// Define HAZARD_PERF_CNT_EN to add load-stall, miss-stall and redirect counters.
module hazard_ctrl_unit
   import pipeline_pkg::*;
#(
   parameter int unsigned CNT_WIDTH = 32
) (
   input  logic                    clk_i,
   input  logic                    reset_i,
   input  logic                    instr_miss_f_i,
   input  logic [REG_ADDR_W-1:0]   rs1_d_i,
   input  logic [REG_ADDR_W-1:0]   rs2_d_i,
   input  logic [REG_ADDR_W-1:0]   rs1_e_i,
   input  logic [REG_ADDR_W-1:0]   rs2_e_i,
   input  logic [REG_ADDR_W-1:0]   rd_e_i,
   input  logic [RESULT_SRC_W-1:0] result_src_e_i,
   input  logic [PC_SRC_W-1:0]     pc_src_i,
   input  logic [REG_ADDR_W-1:0]   rd_m_i,
   input  logic                    reg_write_m_i,
   input  logic [REG_ADDR_W-1:0]   rd_w_i,
   input  logic                    reg_write_w_i,
   input  logic [PC_SRC_W-1:0]     pc_src_reg_i,
   input  logic                    instr_cache_rep_active_i,
   output logic                    stall_f_o,
   output logic                    stall_d_o,
   output logic                    stall_e_o,
   output logic                    stall_m_o,
   output logic                    stall_w_o,
   output logic                    flush_d_o,
   output logic                    flush_e_o,
   output logic [FWD_SEL_W-1:0]    forward_a_e_o,
   output logic [FWD_SEL_W-1:0]    forward_b_e_o
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [CNT_WIDTH-1:0]    load_stall_cnt_o,
   output logic [CNT_WIDTH-1:0]    miss_stall_cnt_o,
   output logic [CNT_WIDTH-1:0]    redirect_flush_cnt_o
`endif
);

   logic lw_stall;
   logic redirect_now;
   logic redirect_prev;

   forward_sel u_fwd_a (
      .rs_e_i        (rs1_e_i),
      .rd_m_i        (rd_m_i),
      .reg_write_m_i (reg_write_m_i),
      .rd_w_i        (rd_w_i),
      .reg_write_w_i (reg_write_w_i),
      .forward_o     (forward_a_e_o)
   );

   forward_sel u_fwd_b (
      .rs_e_i        (rs2_e_i),
      .rd_m_i        (rd_m_i),
      .reg_write_m_i (reg_write_m_i),
      .rd_w_i        (rd_w_i),
      .reg_write_w_i (reg_write_w_i),
      .forward_o     (forward_b_e_o)
   );

   assign lw_stall      = (result_src_e_i == RESULT_SRC_LOAD) && (rd_e_i != '0) &&
                          ((rs1_d_i == rd_e_i) || (rs2_d_i == rd_e_i));
   assign redirect_now  = pc_src_i[PC_SRC_REDIRECT_BIT];
   assign redirect_prev = pc_src_reg_i[PC_SRC_REDIRECT_BIT];

   // Fetch is released for one cycle during a miss so a pending redirect target can load.
   assign stall_f_o = lw_stall ||
                      (instr_miss_f_i && !(redirect_prev && !instr_cache_rep_active_i));
   assign stall_d_o = lw_stall || instr_miss_f_i;
   assign stall_e_o = instr_miss_f_i;
   assign stall_m_o = instr_miss_f_i;
   assign stall_w_o = instr_miss_f_i;

   assign flush_d_o = redirect_now;
   assign flush_e_o = lw_stall || (redirect_now && (!instr_miss_f_i || redirect_prev));

`ifdef HAZARD_PERF_CNT_EN
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         load_stall_cnt_o     <= '0;
         miss_stall_cnt_o     <= '0;
         redirect_flush_cnt_o <= '0;
      end else begin
         if (lw_stall)       load_stall_cnt_o     <= load_stall_cnt_o + CNT_WIDTH'(1);
         if (instr_miss_f_i) miss_stall_cnt_o     <= miss_stall_cnt_o + CNT_WIDTH'(1);
         if (flush_d_o)      redirect_flush_cnt_o <= redirect_flush_cnt_o + CNT_WIDTH'(1);
      end
   end

   logic unused_pc_bits;
   assign unused_pc_bits = ^{pc_src_i[0], pc_src_reg_i[0]};
`else
   logic unused_inputs;
   assign unused_inputs = ^{clk_i, reset_i, pc_src_i[0], pc_src_reg_i[0]};
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Scoreboard bench for hazard_ctrl_unit: stimulus pushes expected controls,
// a negedge monitor pops and compares. Counter checks need HAZARD_PERF_CNT_EN.
module tb_hazard_ctrl_unit;

   localparam int unsigned CW = 32;

   logic       clk_i = 1'b0;
   logic       reset_i;
   logic       instr_miss_f_i;
   logic [4:0] rs1_d_i, rs2_d_i, rs1_e_i, rs2_e_i, rd_e_i, rd_m_i, rd_w_i;
   logic [2:0] result_src_e_i;
   logic [1:0] pc_src_i, pc_src_reg_i;
   logic       reg_write_m_i, reg_write_w_i, instr_cache_rep_active_i;
   logic       stall_f_o, stall_d_o, stall_e_o, stall_m_o, stall_w_o;
   logic       flush_d_o, flush_e_o;
   logic [1:0] forward_a_e_o, forward_b_e_o;
`ifdef HAZARD_PERF_CNT_EN
   logic [CW-1:0] load_stall_cnt_o, miss_stall_cnt_o, redirect_flush_cnt_o;
`endif

   typedef struct {
      logic [10:0] exp;
      string       name;
   } exp_t;

   exp_t q[$];
   logic vld = 1'b0;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk_i = ~clk_i;

   hazard_ctrl_unit #(.CNT_WIDTH(CW)) dut (
      .clk_i                    (clk_i),
      .reset_i                  (reset_i),
      .instr_miss_f_i           (instr_miss_f_i),
      .rs1_d_i                  (rs1_d_i),
      .rs2_d_i                  (rs2_d_i),
      .rs1_e_i                  (rs1_e_i),
      .rs2_e_i                  (rs2_e_i),
      .rd_e_i                   (rd_e_i),
      .result_src_e_i           (result_src_e_i),
      .pc_src_i                 (pc_src_i),
      .rd_m_i                   (rd_m_i),
      .reg_write_m_i            (reg_write_m_i),
      .rd_w_i                   (rd_w_i),
      .reg_write_w_i            (reg_write_w_i),
      .pc_src_reg_i             (pc_src_reg_i),
      .instr_cache_rep_active_i (instr_cache_rep_active_i),
      .stall_f_o                (stall_f_o),
      .stall_d_o                (stall_d_o),
      .stall_e_o                (stall_e_o),
      .stall_m_o                (stall_m_o),
      .stall_w_o                (stall_w_o),
      .flush_d_o                (flush_d_o),
      .flush_e_o                (flush_e_o),
      .forward_a_e_o            (forward_a_e_o),
      .forward_b_e_o            (forward_b_e_o)
`ifdef HAZARD_PERF_CNT_EN
      ,
      .load_stall_cnt_o         (load_stall_cnt_o),
      .miss_stall_cnt_o         (miss_stall_cnt_o),
      .redirect_flush_cnt_o     (redirect_flush_cnt_o)
`endif
   );

   // Expected layout: {stall_f,d,e,m,w, flush_d, flush_e, fwd_a[1:0], fwd_b[1:0]}
   always @(negedge clk_i) begin
      if (vld) begin
         logic [10:0] act;
         exp_t        e;
         act = {stall_f_o, stall_d_o, stall_e_o, stall_m_o, stall_w_o,
                flush_d_o, flush_e_o, forward_a_e_o, forward_b_e_o};
         n_checks++;
         if (q.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty: output act=%b with no expected entry", act);
         end else begin
            e = q.pop_front();
            if (act !== e.exp) begin
               n_fail++;
               $display("FAIL %s: act=%b exp=%b", e.name, act, e.exp);
            end
         end
      end
   end

   task automatic clear_inputs();
      instr_miss_f_i = 0; rs1_d_i = 0; rs2_d_i = 0; rs1_e_i = 0; rs2_e_i = 0;
      rd_e_i = 0; result_src_e_i = 0; pc_src_i = 0; rd_m_i = 0; reg_write_m_i = 0;
      rd_w_i = 0; reg_write_w_i = 0; pc_src_reg_i = 0; instr_cache_rep_active_i = 0;
   endtask

   task automatic push(input logic [10:0] exp, input string name);
      exp_t e;
      e.exp  = exp;
      e.name = name;
      q.push_back(e);
      vld = 1'b1;
   endtask

   // Control-path vector: drives hazard inputs with forwarding regs held at x0.
   task automatic ctl(input logic miss, input logic rep, input logic [1:0] pcs,
                      input logic [1:0] pcsr, input logic [2:0] rse, input logic [4:0] rs1d,
                      input logic [4:0] rs2d, input logic [4:0] rde,
                      input logic [6:0] exp_sf, input string name);
      @(posedge clk_i); #1;
      clear_inputs();
      instr_miss_f_i = miss; instr_cache_rep_active_i = rep; pc_src_i = pcs;
      pc_src_reg_i = pcsr; result_src_e_i = rse; rs1_d_i = rs1d; rs2_d_i = rs2d;
      rd_e_i = rde;
      push({exp_sf, 4'b0000}, name);
   endtask

   task automatic fwd(input logic [4:0] rs1e, input logic [4:0] rs2e, input logic [4:0] rdm,
                      input logic wm, input logic [4:0] rdw, input logic ww,
                      input logic [1:0] ea, input logic [1:0] eb, input string name);
      @(posedge clk_i); #1;
      clear_inputs();
      rs1_e_i = rs1e; rs2_e_i = rs2e; rd_m_i = rdm; reg_write_m_i = wm;
      rd_w_i = rdw; reg_write_w_i = ww;
      push({7'b0, ea, eb}, name);
   endtask

   task automatic idle();
      @(posedge clk_i); #1;
      clear_inputs();
      vld = 1'b0;
   endtask

   task automatic check_cnt(input logic [CW-1:0] act, input logic [CW-1:0] exp,
                            input string name);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: act=%0d exp=%0d", name, act, exp);
      end
   endtask

   initial begin
      clear_inputs();
      reset_i = 1'b1;
      repeat (2) @(posedge clk_i);
      #1 reset_i = 1'b0;

      //      miss rep pcs    pcsr   rse     rs1d rs2d rde  {sf sd se sm sw fd fe}
      ctl(0, 0, 2'b00, 2'b00, 3'b000, 0, 0, 0, 7'b0000000, "reset_idle");
      ctl(0, 0, 2'b00, 2'b00, 3'b100, 1, 0, 1, 7'b1100001, "load_use_rs1");
      ctl(0, 0, 2'b00, 2'b00, 3'b100, 0, 2, 2, 7'b1100001, "load_use_rs2");
      ctl(0, 0, 2'b00, 2'b00, 3'b100, 0, 0, 0, 7'b0000000, "load_rd_x0");
      ctl(0, 0, 2'b00, 2'b00, 3'b000, 1, 0, 1, 7'b0000000, "non_load_match");
      ctl(1, 1, 2'b00, 2'b00, 3'b000, 0, 0, 0, 7'b1111100, "miss_no_branch");
      ctl(0, 0, 2'b11, 2'b00, 3'b000, 0, 0, 0, 7'b0000011, "hit_mispredict");
      ctl(1, 0, 2'b11, 2'b00, 3'b000, 0, 0, 0, 7'b1111110, "miss_mp_cycle1");
      ctl(1, 0, 2'b11, 2'b11, 3'b000, 0, 0, 0, 7'b0111111, "miss_mp_cycle2");
      ctl(1, 1, 2'b00, 2'b00, 3'b000, 0, 0, 0, 7'b1111100, "miss_mp_cycle3_m1");
      ctl(0, 1, 2'b00, 2'b00, 3'b000, 0, 0, 0, 7'b0000000, "miss_mp_cycle3_m0");
      ctl(1, 0, 2'b01, 2'b00, 3'b000, 0, 0, 0, 7'b1111100, "miss_pred_rep0");
      ctl(1, 1, 2'b01, 2'b00, 3'b000, 0, 0, 0, 7'b1111100, "miss_pred_rep1");
      ctl(1, 1, 2'b00, 2'b11, 3'b000, 0, 0, 0, 7'b1111100, "miss_redirprev_rep");
      ctl(1, 0, 2'b00, 2'b00, 3'b100, 3, 0, 3, 7'b1111101, "load_use_and_miss");

      fwd(5, 6, 5, 1, 6, 1, 2'b10, 2'b01, "fwd_mem_a_wb_b");
      fwd(5, 6, 5, 0, 5, 1, 2'b01, 2'b00, "fwd_wb_a_only");
      fwd(7, 7, 7, 1, 7, 1, 2'b10, 2'b10, "fwd_both_mem_wins");
      fwd(0, 0, 0, 1, 0, 1, 2'b00, 2'b00, "fwd_x0_never");

      // Sweep every rs with M/W match/mismatch and write-enable combinations.
      for (int rs = 0; rs < 32; rs++) begin
         for (int c = 0; c < 16; c++) begin
            logic       mm, wm_, wmatch, ww_;
            logic [4:0] rs5, rdm, rdw;
            logic [1:0] e;
            mm = c[0]; wmatch = c[1]; wm_ = c[2]; ww_ = c[3];
            rs5 = 5'(rs);
            rdm = mm     ? rs5 : 5'(rs5 + 5'd1);
            rdw = wmatch ? rs5 : 5'(rs5 + 5'd2);
            if (rs5 == 5'd0)      e = 2'b00;
            else if (mm && wm_)   e = 2'b10;
            else if (wmatch && ww_) e = 2'b01;
            else                  e = 2'b00;
            fwd(rs5, rs5, rdm, wm_, rdw, ww_, e, e, "fwd_sweep");
         end
      end
      idle();

      for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk_i);
      n_checks++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: act=%0d pending exp=0", q.size());
      end

`ifdef HAZARD_PERF_CNT_EN
      @(posedge clk_i); #1 reset_i = 1'b1;
      #1;
      check_cnt(load_stall_cnt_o,     '0, "cnt_load_async_reset");
      check_cnt(miss_stall_cnt_o,     '0, "cnt_miss_async_reset");
      check_cnt(redirect_flush_cnt_o, '0, "cnt_redir_async_reset");
      @(posedge clk_i); #1 reset_i = 1'b0;
      for (int i = 0; i < 3; i++)
         ctl(0, 0, 2'b00, 2'b00, 3'b100, 4, 0, 4, 7'b1100001, "cnt_load_vec");
      idle();
      check_cnt(load_stall_cnt_o,     CW'(3), "cnt_load_three");
      check_cnt(miss_stall_cnt_o,     '0,     "cnt_miss_zero");
      check_cnt(redirect_flush_cnt_o, '0,     "cnt_redir_zero");
      repeat (2) @(posedge clk_i);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
- Central hazard controller for the 5-stage RISC-V pipeline (F/D/E/M/W).
- Generates per-stage stall and flush controls for load-use hazards, instruction-cache misses and branch redirects, and produces Execute-stage operand forwarding selects.
- All control outputs are purely combinational from the inputs.
- Clock/reset serve only the optional event counters.

Parameters:
- CNT_WIDTH, 32, width of each optional event counter.

Ports:
- clk_i  in  1  pipeline clock
- reset_i  in  1  asynchronous, active-high reset
- instr_miss_f_i  in  1  I-cache miss for the Fetch-stage access
- rs1_d_i  in  5  Decode source register 1
- rs2_d_i  in  5  Decode source register 2
- rs1_e_i  in  5  Execute source register 1
- rs2_e_i  in  5  Execute source register 2
- rd_e_i  in  5  Execute destination register
- result_src_e_i  in  3  Execute result-source select; 3'b100 = load
- pc_src_i  in  2  current PC select; bit1 = 1 means redirect/mispredict
- rd_m_i  in  5  Memory-stage destination register
- reg_write_m_i  in  1  Memory-stage register write enable
- rd_w_i  in  5  Writeback-stage destination register
- reg_write_w_i  in  1  Writeback-stage register write enable
- pc_src_reg_i  in  2  pc_src registered one cycle earlier (external)
- instr_cache_rep_active_i  in  1  I-cache line replacement in progress
- stall_f_o, stall_d_o, stall_e_o, stall_m_o, stall_w_o  out  1 each  stage stalls
- flush_d_o, flush_e_o  out  1 each  stage flushes
- forward_a_e_o  out  2  rs1 operand select
- forward_b_e_o  out  2  rs2 operand select
- Counter ports: see Optional Feature.

Behaviour:
- Forwarding encodings: 00 = register file, 01 = Writeback result, 10 = Memory result.
- forward_a_e_o:
  - 00 if rs1_e == 0.
  - Else 10 if rs1_e == rd_m and reg_write_m.
  - Else 01 if rs1_e == rd_w and reg_write_w.
  - Else 00.
  - Memory wins when both stages match.
- forward_b_e_o: identical rule using rs2_e.
- lw_stall = (result_src_e == 3'b100) and (rd_e != 0) and (rs1_d == rd_e or rs2_d == rd_e).
- redirect_now = pc_src[1]; redirect_prev = pc_src_reg[1].
- Stall equations:
  - stall_f = lw_stall or (instr_miss_f and not (redirect_prev and not instr_cache_rep_active)).
  - Fetch is released for one cycle when a redirect is pending during a miss and no line replacement is active, so the PC can load the target.
  - stall_d = lw_stall or instr_miss_f.
  - stall_e = stall_m = stall_w = instr_miss_f.
- Flush equations:
  - flush_d = redirect_now.
  - flush_e = lw_stall or (redirect_now and (not instr_miss_f or redirect_prev)).
- Simultaneous stall and flush on one stage: the pipeline register applies flush over stall. The unit itself does not arbitrate.
- Outputs have zero latency (combinational) and are independent of reset_i.
- No internal state without the optional feature.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- When defined, add three outputs, each CNT_WIDTH bits:
  - load_stall_cnt_o: increments each clock where lw_stall = 1.
  - miss_stall_cnt_o: increments each clock where instr_miss_f = 1.
  - redirect_flush_cnt_o: increments each clock where flush_d = 1.
- Counters are cleared asynchronously to 0 by reset_i and wrap modulo 2^CNT_WIDTH.
- When undefined: these ports and registers do not exist; clk_i and reset_i are unused.

Decomposition:
- Shared package (pipeline_pkg):
  - forwarding select constants NO_FORWARD = 2'b00, WB_FORWARD = 2'b01, MEM_FORWARD = 2'b10;
  - RESULT_SRC_LOAD = 3'b100;
  - PC-select redirect bit index.
- Natural sub-module: forward_sel, a single-operand forwarding comparator instantiated twice (rs1, rs2).
- Stall/flush logic and the counters stay in the top module.

Test Plan:
- Forwarding sweep: for each rs1_e = rs2_e = 0..31, sweep rd_m and rd_w 0..31 with reg_write_m/w toggled.
  - rs = 0 -> 00.
  - Match on M with reg_write_m = 1 -> 10, even when W also matches.
  - Match on W only -> 01.
  - Otherwise 00.
- Load-use hazard:
  - result_src_e = 100, rs1_d = 1, rd_e = 1 -> stall_f = stall_d = 1, flush_e = 1, stall_e/m/w = 0.
  - Same with rs2_d = 2, rd_e = 2.
  - rd_e = 0 -> no stall.
- Cache miss, no branch: instr_miss_f = 1, rep_active = 1, pc_src = 00 -> all five stalls = 1, flush_d = flush_e = 0.
- Cache hit plus mispredict: instr_miss_f = 0, pc_src = 11, pc_src_reg = 00 -> all stalls 0, flush_d = flush_e = 1.
- Miss plus mispredict sequence:
  - Cycle 1 (miss = 1, rep = 0, pc_src = 11, pc_src_reg = 00) -> all stalls 1, flush_d = 1, flush_e = 0.
  - Cycle 2 (pc_src_reg = 11) -> stall_f = 0, stall_d/e/m/w = 1, flush_d = flush_e = 1.
  - Cycle 3 (rep = 1, pc_src = pc_src_reg = 00, miss = x) -> all stalls = x, flushes 0.
- Miss plus correctly predicted branch: pc_src = 01, miss = 1, rep = 0 then 1 -> all stalls 1 both cycles, flush_d = 0.
- Feature on: assert reset_i mid-count -> counters read 0 immediately.
  - Then 3 load-stall cycles -> load_stall_cnt_o = 3.
